// File: rtl/nbcac_12di_encoder_seq.sv
// Iterative NBCAC 12-bit encoder: resolves one codeword bit per clock by greedy
// subtraction against the fixed weight table shared with nbcac_12di_decoder_core.
module nbcac_12di_encoder_seq #(
  parameter int unsigned DW = 12,
  parameter int unsigned CW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [4:0] KFirst = 5'd2;
  localparam logic [4:0] KLast  = 5'd17;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] code_q, code_d;
  logic [12:0]   r_q, r_d;
  logic [4:0]    k_q, k_d;

  logic [12:0]   weight_k;
  logic [CW-1:0] bit_mask;
  logic          take;

  // Must stay identical to the decoder core's table.
  function automatic logic [12:0] weight(input logic [4:0] k);
    logic [12:0] w;
    unique case (k)
      5'd1:    w = 13'd1;
      5'd2:    w = 13'd1974;
      5'd3:    w = 13'd1220;
      5'd4:    w = 13'd754;
      5'd5:    w = 13'd466;
      5'd6:    w = 13'd288;
      5'd7:    w = 13'd178;
      5'd8:    w = 13'd110;
      5'd9:    w = 13'd68;
      5'd10:   w = 13'd42;
      5'd11:   w = 13'd26;
      5'd12:   w = 13'd16;
      5'd13:   w = 13'd10;
      5'd14:   w = 13'd6;
      5'd15:   w = 13'd4;
      5'd16:   w = 13'd2;
      5'd17:   w = 13'd2;
      default: w = 13'd0;
    endcase
    return w;
  endfunction

  always_comb begin
    weight_k = weight(k_q);
    bit_mask = {{(CW-1){1'b0}}, 1'b1} << (k_q - 5'd1);
    take     = (r_q >= weight_k);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    r_d     = r_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Bit 0 goes straight to d[1]; the remainder is resolved greedily.
          r_d     = {1'b0, in_data[DW-1:1], 1'b0};
          code_d  = {{(CW-1){1'b0}}, in_data[0]};
          k_d     = KFirst;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (take) begin
          code_d = code_q | bit_mask;
          r_d    = r_q - weight_k;
        end
        if (k_q == KLast) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      code_q  <= '0;
      r_q     <= '0;
      k_q     <= KFirst;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    out_code  = code_q;
  end

`ifndef SYNTHESIS
  // The weight table guarantees the residual is fully consumed by d[17].
  always_ff @(posedge clk) begin
    if (!rst && state_q == StBusy && state_d == StDone) begin
      assert (r_d == 13'd0);
    end
  end
`endif

endmodule

// File: tb/tb_nbcac_12di_encoder_seq.sv
// Self-checking bench for nbcac_12di_encoder_seq: directed vectors, full sweep with a
// decoder model, random words with random backpressure, and reset behaviour.
module tb_nbcac_12di_encoder_seq;

  logic        clk;
  logic        rst;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] out_code;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int unsigned errors;
  int unsigned checks;

  int w_tab [17] = '{1, 1974, 1220, 754, 466, 288, 178, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2};

  nbcac_12di_encoder_seq #(
    .DW(12),
    .CW(17)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_code (out_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_encode(input int v);
    logic [16:0] c;
    int r;
    c = '0;
    c[0] = v[0];
    r = v - (v % 2);
    for (int k = 2; k <= 17; k++) begin
      if (r >= w_tab[k-1]) begin
        c[k-1] = 1'b1;
        r -= w_tab[k-1];
      end
    end
    return c;
  endfunction

  function automatic int ref_decode(input logic [16:0] c);
    int s;
    s = 0;
    for (int k = 1; k <= 17; k++) begin
      if (c[k-1]) s += w_tab[k-1];
    end
    return s;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_word(input string tag, input logic [11:0] v, input logic [16:0] exp,
                          input int stall, input bit full);
    int lat;
    chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    if (full) begin
      chk({tag, ":busy_after_accept"}, 32'(busy), 32'd1);
      chk({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    end
    // Keep offering junk while busy; none of it may be taken.
    in_data = 12'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      in_data = 12'($urandom);
    end
    chk({tag, ":latency"}, 32'(lat), 32'd16);
    chk({tag, ":code"}, 32'(out_code), 32'(exp));
    chk({tag, ":decode"}, 32'(ref_decode(out_code)), 32'(v));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ":stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ":stall_code"}, 32'(out_code), 32'(exp));
      chk({tag, ":stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    if (full) chk({tag, ":in_ready_at_hs"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ":in_ready_after_hs"}, 32'(in_ready), 32'd1);
    if (full) chk({tag, ":code_kept"}, 32'(out_code), 32'(exp));
  endtask

  initial begin
    bit saw_valid;
    logic [11:0] v;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 12'd5;
    out_ready = 1'b0;

    // in_valid asserted together with rst must be ignored.
    repeat (3) @(negedge clk);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:out_code", 32'(out_code), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst:busy", 32'(busy), 32'd0);

    run_word("zero", 12'd0, 17'h00000, 0, 1'b1);
    run_word("one", 12'd1, 17'h00001, 0, 1'b1);
    run_word("v2000", 12'd2000, 17'h00402, 0, 1'b1);
    run_word("v1973", 12'd1973, 17'h05555, 0, 1'b1);
    run_word("v4095", 12'd4095, 17'h0148F, 5, 1'b1);

    // Reset in the 8th BUSY cycle discards the word.
    in_data  = 12'd4095;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst:still_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:out_valid", 32'(out_valid), 32'd0);
    chk("midrst:in_ready", 32'(in_ready), 32'd1);
    chk("midrst:out_code", 32'(out_code), 32'd0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst:no_valid", 32'(saw_valid), 32'd0);

    for (int i = 0; i < 120; i++) begin
      v = 12'($urandom);
      run_word("rand", v, ref_encode(int'(v)), int'($urandom_range(0, 3)), 1'b1);
    end

    for (int i = 0; i < 4096; i++) begin
      v = 12'(i);
      run_word("sweep", v, ref_encode(i), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
